// File: rtl/spi_mc_pkg.sv
// Shared types for the multi-chip-select SPI master: FSM states, SPI mode
// encoding {CPOL,CPHA} and the four standard mode constants.
package spi_mc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    DONE
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter and SCK generator. tick marks the last clock of each
// (div+1)-clock half period; lead/trail qualify it while SCK is toggling.
module spi_sclk_div #(
  parameter int DIV_W = 8
) (
  input  logic             sclk_senddata,
  input  logic             rst,
  input  logic             run,
  input  logic             sck_en,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sck_level
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;

  // Counter wraps on tick, so div = all-ones never needs an extra bit.
  always_comb begin
    tick       = run && (cnt_q == div);
    cnt_d      = (!run || tick) ? '0 : cnt_q + 1'b1;
    lead_edge  = tick && sck_en && (sck_q == cpol);
    trail_edge = tick && sck_en && (sck_q != cpol);
    sck_d      = sck_en ? (tick ? ~sck_q : sck_q) : cpol;
  end

  always_ff @(posedge sclk_senddata or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_level = sck_q;

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with per-transfer mode, divider and chip-select selection.
// Defining SPI_LOOPBACK_EN adds a loopback input that routes MOSI to the sampler.
module spi_master_mc
  import spi_mc_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 2,
  parameter  int DIV_W  = 8,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              sclk_senddata,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int                EDGE_W    = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d, sel_n;
  logic [DATA_W-1:0] tx_sreg_q, tx_sreg_d;
  logic [DATA_W-1:0] rx_sreg_q, rx_sreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, cpol_next, miso_in;
  logic              tick, lead_edge, trail_edge, shift_edge, sample_edge;

  assign accept      = start && !busy_q;
  assign cpol_next   = accept ? mode[1] : mode_q.cpol;
  assign shift_edge  = mode_q.cpha ? lead_edge : trail_edge;
  assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;

`ifdef SPI_LOOPBACK_EN
  logic loop_q, loop_d;
  assign miso_in = loop_q ? mosi_q : spi_miso;
`else
  assign miso_in = spi_miso;
`endif

  spi_sclk_div #(.DIV_W(DIV_W)) u_sclk_div (
    .sclk_senddata (sclk_senddata),
    .rst           (rst),
    .run           (busy_q),
    .sck_en        (state_q == XFER),
    .cpol          (cpol_next),
    .div           (div_q),
    .tick          (tick),
    .lead_edge     (lead_edge),
    .trail_edge    (trail_edge),
    .sck_level     (spi_sck)
  );

  // Out-of-range selects (and loopback) leave every chip select high.
  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CS_W'(i)) sel_n[i] = 1'b0;
`ifdef SPI_LOOPBACK_EN
    if (loopback) sel_n = '1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    div_d      = div_q;
    cs_n_d     = cs_n_q;
    tx_sreg_d  = tx_sreg_q;
    rx_sreg_d  = rx_sreg_q;
    rx_data_d  = rx_data_q;
    edge_cnt_d = edge_cnt_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
`ifdef SPI_LOOPBACK_EN
    loop_d     = loop_q;
`endif
    if (accept) begin
      // MSB goes out immediately; CPHA=1 re-drives it on the first leading edge.
      state_d    = LEAD;
      mode_d     = spi_mode_t'(mode);
      div_d      = div;
      cs_n_d     = sel_n;
      mosi_d     = tx_data[DATA_W-1];
      tx_sreg_d  = mode[0] ? tx_data : (tx_data << 1);
      edge_cnt_d = '0;
`ifdef SPI_LOOPBACK_EN
      loop_d     = loopback;
`endif
    end else begin
      case (state_q)
        LEAD: if (tick) state_d = XFER;
        XFER: begin
          if (shift_edge) begin
            mosi_d    = tx_sreg_q[DATA_W-1];
            tx_sreg_d = tx_sreg_q << 1;
          end
          if (sample_edge) rx_sreg_d = {rx_sreg_q[DATA_W-2:0], miso_in};
          if (tick) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
            if (edge_cnt_q == LAST_EDGE) state_d = TRAIL;
          end
        end
        TRAIL: if (tick) begin
          state_d   = DONE;
          cs_n_d    = '1;
          done_d    = 1'b1;
          rx_data_d = rx_sreg_q;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == LEAD) || (state_d == XFER) || (state_d == TRAIL);
  end

  always_ff @(posedge sclk_senddata or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      div_q      <= '0;
      cs_n_q     <= '1;
      tx_sreg_q  <= '0;
      rx_sreg_q  <= '0;
      rx_data_q  <= '0;
      edge_cnt_q <= '0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      cs_n_q     <= cs_n_d;
      tx_sreg_q  <= tx_sreg_d;
      rx_sreg_q  <= rx_sreg_d;
      rx_data_q  <= rx_data_d;
      edge_cnt_q <= edge_cnt_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SPI_LOOPBACK_EN
      loop_q     <= loop_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: 8-bit/2-CS, 16-bit/4-CS and 8-bit/3-CS instances.
// Expected transfers are queued at start and checked when done pulses.
module tb_spi_master_mc;
  import spi_mc_pkg::*;

  typedef struct {
    logic [7:0] rx;
    int         cyc;
    logic       cpol;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start8 = 1'b0, busy8, done8, sck8, mosi8, miso8;
  logic [1:0] mode8 = 2'b00, csn8;
  logic [7:0] div8 = 8'd0, tx8 = 8'd0, rx8;
  logic [0:0] cs8 = 1'b0;

  logic        start16 = 1'b0, busy16, done16, sck16, mosi16;
  logic [1:0]  cs16 = 2'd0;
  logic [3:0]  csn16;
  logic [15:0] tx16 = 16'd0, rx16;

  logic       start3 = 1'b0, busy3, done3, sck3, mosi3;
  logic [1:0] cs3 = 2'd0;
  logic [2:0] csn3;
  logic [7:0] tx3 = 8'd0, rx3;

  logic       slv_loop = 1'b1;
  logic [7:0] slv_sreg = 8'd0;
  logic [7:0] mosi_cap = 8'd0;

  assign miso8 = slv_loop ? mosi8 : slv_sreg[7];
  always @(negedge sck8) slv_sreg <= slv_sreg << 1;
  always @(posedge sck8) mosi_cap <= {mosi_cap[6:0], mosi8};

  spi_master_mc dut8 (
    .sclk_senddata(clk), .rst(rst), .start(start8), .mode(mode8), .div(div8),
    .cs_sel(cs8), .tx_data(tx8),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_data(rx8), .busy(busy8), .done(done8), .spi_sck(sck8),
    .spi_mosi(mosi8), .spi_miso(miso8), .spi_cs_n(csn8)
  );

  spi_master_mc #(.DATA_W(16), .NUM_CS(4)) dut16 (
    .sclk_senddata(clk), .rst(rst), .start(start16), .mode(2'b00), .div(8'd0),
    .cs_sel(cs16), .tx_data(tx16),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_data(rx16), .busy(busy16), .done(done16), .spi_sck(sck16),
    .spi_mosi(mosi16), .spi_miso(mosi16), .spi_cs_n(csn16)
  );

  // A 2-bit select with only three lines can name an absent slave.
  spi_master_mc #(.DATA_W(8), .NUM_CS(3)) dut3 (
    .sclk_senddata(clk), .rst(rst), .start(start3), .mode(2'b00), .div(8'd0),
    .cs_sel(cs3), .tx_data(tx3),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_data(rx3), .busy(busy3), .done(done3), .spi_sck(sck3),
    .spi_mosi(mosi3), .spi_miso(mosi3), .spi_cs_n(csn3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [7:0] rx, input int done_cyc, input logic cpol);
    exp_t e;
    e.rx   = rx;
    e.cyc  = done_cyc;
    e.cpol = cpol;
    sb.push_back(e);
  endtask

  // Called just after a rising edge with dut8 idle; returns in the LEAD cycle.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d,
                               input logic [7:0] tx, input logic cs,
                               input logic [7:0] exp_rx);
    mode8  = m;
    div8   = d;
    tx8    = tx;
    cs8    = cs;
    start8 = 1'b1;
    pushExp(exp_rx, cyc + 18 * (int'(d) + 1) + 1, m[1]);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput({"drain_", tag}, sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst && done8) begin
      checkOutput("sb_nonempty_at_done", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checkOutput("rx_data", 32'(rx8), 32'(mon_e.rx));
        checkOutput("done_cycle", cyc, mon_e.cyc);
        checkOutput("sck_idle_done", 32'(sck8), 32'(mon_e.cpol));
        checkOutput("cs_high_done", 32'(csn8), 32'h3);
        checkOutput("busy_done", 32'(busy8), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, k;
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_cs_n", 32'(csn8), 32'h3);
    checkOutput("rst_sck", 32'(sck8), 0);
    checkOutput("rst_mosi", 32'(mosi8), 0);
    checkOutput("rst_busy", 32'(busy8), 0);
    checkOutput("rst_done", 32'(done8), 0);
    checkOutput("rst_rx", 32'(rx8), 0);
    checkOutput("rst_cs_n16", 32'(csn16), 32'hF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] mode 0, div 1, 0xA5 out, slave returns 0x3C");
    slv_loop = 1'b0;
    slv_sreg = 8'h3C;
    applyStimulus(MODE0, 8'd1, 8'hA5, 1'b0, 8'h3C);
    checkOutput("lead_cs_n", 32'(csn8), 32'h2);
    checkOutput("lead_busy", 32'(busy8), 1);
    checkOutput("lead_mosi_msb", 32'(mosi8), 1);
    waitIdle("mode0", 200);
    checkOutput("mosi_bits", 32'(mosi_cap), 32'hA5);

    $display("[TB] all modes, loopback slave, 0x81");
    slv_loop = 1'b1;
    for (int m = 0; m < 4; m++) begin
      applyStimulus(2'(m), 8'd2, 8'h81, 1'b1, 8'h81);
      checkOutput("lead_sck_cpol", 32'(sck8), 32'((m >> 1) & 1));
      checkOutput("lead_cs_n1", 32'(csn8), 32'h1);
      waitIdle("modes", 300);
      checkOutput("idle_sck_cpol", 32'(sck8), 32'((m >> 1) & 1));
    end

    $display("[TB] start and input changes while busy");
    applyStimulus(MODE0, 8'd1, 8'h5A, 1'b0, 8'h5A);
    repeat (5) @(posedge clk);
    #1;
    start8 = 1'b1;
    tx8    = 8'hFF;
    mode8  = 2'b11;
    div8   = 8'd0;
    cs8    = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy_ignored_start", 32'(busy8), 1);
    checkOutput("cs_unchanged", 32'(csn8), 32'h2);
    start8 = 1'b0;
    waitIdle("busy_start", 200);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("no_queued_xfer", 32'(busy8), 0);

    $display("[TB] back-to-back with start held through DONE");
    mode8  = MODE0;
    div8   = 8'd1;
    cs8    = 1'b0;
    tx8    = 8'h3C;
    start8 = 1'b1;
    n = cyc;
    pushExp(8'h3C, n + 37, 1'b0);
    pushExp(8'hC3, n + 74, 1'b0);
    @(posedge clk); #1;
    tx8 = 8'hC3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done8 && k < 200);
    checkOutput("b2b_first_done_seen", 32'(done8), 1);
    @(posedge clk); #1;
    start8 = 1'b0;
    checkOutput("b2b_cs_gap", 32'(csn8), 32'h2);
    waitIdle("b2b", 200);

    $display("[TB] reset in the middle of XFER");
    applyStimulus(MODE1, 8'd3, 8'h77, 1'b0, 8'h77);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_cs_n", 32'(csn8), 32'h3);
    checkOutput("abort_busy", 32'(busy8), 0);
    checkOutput("abort_sck", 32'(sck8), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("abort_no_busy", 32'(busy8), 0);
    applyStimulus(MODE0, 8'd0, 8'h96, 1'b1, 8'h96);
    waitIdle("after_reset", 100);

    $display("[TB] 16-bit, four chip selects, cs_sel 3, div 0");
    tx16    = 16'hBEEF;
    cs16    = 2'd3;
    start16 = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start16 = 1'b0;
    checkOutput("w16_cs_n", 32'(csn16), 32'h7);
    checkOutput("w16_mosi_msb", 32'(mosi16), 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done16 && k < 100);
    checkOutput("w16_done_seen", 32'(done16), 1);
    checkOutput("w16_done_cycle", cyc, n + 35);
    checkOutput("w16_rx", 32'(rx16), 32'hBEEF);
    checkOutput("w16_cs_high", 32'(csn16), 32'hF);

    $display("[TB] select beyond the last chip select");
    @(posedge clk); #1;
    tx3    = 8'h42;
    cs3    = 2'd3;
    start3 = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start3 = 1'b0;
    checkOutput("oor_cs_n", 32'(csn3), 32'h7);
    checkOutput("oor_busy", 32'(busy3), 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done3 && k < 100);
    checkOutput("oor_done_seen", 32'(done3), 1);
    checkOutput("oor_done_cycle", cyc, n + 19);
    checkOutput("oor_rx", 32'(rx3), 32'h42);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
